// File: rtl/mem_pkg.sv
// Shared types and constants for the load/store unit.
package mem_pkg;

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} mau_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // A request is rejected when misaligned for its width, when funct3 is not
    // a defined access type, or when an unsigned load type is used as a store.
    function automatic logic req_is_err(input logic we, input logic [2:0] funct3,
                                        input logic [1:0] lane);
        logic err;
        case (funct3)
            F3_B:    err = 1'b0;
            F3_H:    err = lane[0];
            F3_W:    err = (lane != 2'b00);
            F3_BU:   err = we;
            F3_HU:   err = we | lane[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Selects the addressed byte/halfword lane of a RAM word and extends it.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection and sign/zero extension by access type.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        data     = '0;
        byte_sel = word[{lane, 3'b000} +: 8];
        half_sel = lane[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data = {24'h0, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data = {16'h0, half_sel};
            F3_W:    data = word;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator: one request at a time, sub-word stores via
// read-modify-write against a word-only RAM, one-cycle response strobe.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr_en,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    mau_state_t        state, next_state;
    logic              lat_we;
    logic [2:0]        lat_funct3;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;
    logic [31:0]       merge_buf;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_err_q;
    logic              accept;
    logic              req_err;
    logic [31:0]       load_data;
    logic [31:0]       merged;

    assign accept  = req_valid & req_ready;
    assign req_err = req_is_err(req_we, req_funct3, req_addr[1:0]);

    load_align u_load_align (
        .word   (mem_rdata),
        .lane   (lat_addr[1:0]),
        .funct3 (lat_funct3),
        .data   (load_data)
    );

    // Next-state selection; errors skip the RAM entirely, SW skips the read.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)                next_state = RESP;
                    else if (!req_we)           next_state = READ;
                    else if (req_funct3 == F3_W) next_state = WRITE;
                    else                        next_state = READ;
                end
            end
            READ:    next_state = lat_we ? WRITE : RESP;
            WRITE:   next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State, request latch, merge buffer and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            lat_we      <= 1'b0;
            lat_funct3  <= '0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            merge_buf   <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state <= next_state;
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_we      <= req_we;
                        lat_funct3  <= req_funct3;
                        lat_addr    <= req_addr;
                        lat_wdata   <= req_wdata;
                        rsp_err_q   <= req_err;
                        rsp_rdata_q <= '0;
                    end
                end
                READ: begin
                    if (lat_we) merge_buf   <= mem_rdata;
                    else        rsp_rdata_q <= load_data;
                end
                RESP: begin
                    rsp_rdata_q <= '0;
                    rsp_err_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Store merge: replace only the addressed lane of the buffered word.
    always_comb begin
        merged = merge_buf;
        case (lat_funct3)
            F3_W:    merged = lat_wdata;
            F3_B:    merged[{lat_addr[1:0], 3'b000} +: 8] = lat_wdata[7:0];
            F3_H:    merged[{lat_addr[1], 4'b0000} +: 16] = lat_wdata[15:0];
            default: merged = merge_buf;
        endcase
    end

    // Outputs are forced low while reset is high so an aborted write never reaches the RAM.
    always_comb begin
        req_ready = (state == IDLE) && !reset;
        rsp_valid = (state == RESP) && !reset;
        rsp_rdata = reset ? 32'h0 : rsp_rdata_q;
        rsp_err   = reset ? 1'b0 : rsp_err_q;
        mem_wr_en = (state == WRITE) && !reset;
        mem_addr  = '0;
        if (!reset && (state == READ || state == WRITE))
            mem_addr = {lat_addr[ADDR_W-1:2], 2'b00};
        mem_wdata = mem_wr_en ? merged : 32'h0;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a word RAM and a byte-level reference model.
`timescale 1ns/1ps
module tb_mem_access_unit;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] mem_addr;
    logic          mem_wr_en;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    logic [31:0]   ram [64];
    logic [31:0]   ref_mem [64];
    int            wr_count;
    logic [AW-1:0] last_wr_addr;
    logic [31:0]   last_wr_data;
    int            total = 0;
    int            bad = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // RAM environment: combinational read, write on the rising edge.
    assign mem_rdata = ram[mem_addr[7:2]];

    initial wr_count = 0;
    always @(posedge clk) begin
        if (mem_wr_en) begin
            ram[mem_addr[7:2]] <= mem_wdata;
            wr_count           <= wr_count + 1;
            last_wr_addr       <= mem_addr;
            last_wr_data       <= mem_wdata;
        end
    end

    // ---------------- reference model ----------------
    function automatic bit model_err(input bit we, input int f3, input int addr);
        bit illegal  = (f3 == 3) || (f3 == 6) || (f3 == 7);
        bit misalign = ((f3 == 1 || f3 == 5) && (addr % 2 != 0)) || (f3 == 2 && addr % 4 != 0);
        bit bad_st   = we && (f3 == 4 || f3 == 5);
        return illegal || misalign || bad_st;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input int f3, input int addr);
        int unsigned bv = (w >> (8 * (addr % 4))) & 32'hFF;
        int unsigned hv = (w >> (16 * ((addr % 4) / 2))) & 32'hFFFF;
        case (f3)
            0: return (bv >= 128) ? bv + 32'hFFFF_FF00 : bv;
            1: return (hv >= 32768) ? hv + 32'hFFFF_0000 : hv;
            4: return bv;
            5: return hv;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] w, input int f3,
                                                input int addr, input logic [31:0] wd);
        int n = (f3 == 0) ? 1 : (f3 == 1) ? 2 : 4;
        logic [31:0] r = w;
        for (int i = 0; i < n; i++) begin
            int p = addr % 4 + i;
            r = (r & ~(32'hFF << (8 * p))) | (((wd >> (8 * i)) & 32'hFF) << (8 * p));
        end
        return r;
    endfunction

    function automatic int model_latency(input bit we, input int f3, input int addr);
        if (model_err(we, f3, addr)) return 1;
        if (!we || f3 == 2) return 2;
        return 3;
    endfunction

    // Drive one request from an IDLE negedge; return at the IDLE negedge after the response.
    task automatic do_req(input bit we, input logic [2:0] f3, input logic [AW-1:0] addr,
                          input logic [31:0] wd, output int lat, output logic [31:0] rd,
                          output logic er, output int nwr);
        int w0 = wr_count;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        lat = -1; rd = 'x; er = 1'bx;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 1; k <= 6 && lat < 0; k++) begin
            if (rsp_valid) begin
                lat = k; rd = rsp_rdata; er = rsp_err;
            end
            @(posedge clk);
            @(negedge clk);
        end
        nwr = wr_count - w0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 64; i++) begin
            ram[i] <= 32'(100 + i);
            ref_mem[i] = 32'(100 + i);
        end
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        total++; if ({req_ready, rsp_valid, rsp_err, mem_wr_en} !== 4'b0) begin bad++;
            $display("FAIL reset_flags got %b want 0000", {req_ready, rsp_valid, rsp_err, mem_wr_en}); end
        total++; if ({rsp_rdata, mem_addr, mem_wdata} !== '0) begin bad++;
            $display("FAIL reset_data got %h/%h/%h want 0", rsp_rdata, mem_addr, mem_wdata); end
        reset = 1'b0;
        #1;
        total++; if (req_ready !== 1'b1 || mem_addr !== '0) begin bad++;
            $display("FAIL idle_after_reset ready=%b addr=%h want 1/0", req_ready, mem_addr); end
    endtask

    task automatic test_lw();
        int lat, nwr; logic [31:0] rd; logic er;
        do_req(1'b0, 3'b010, 32'h4, 32'h0, lat, rd, er, nwr);
        total++; if (lat !== 2 || rd !== 32'h65 || er !== 1'b0 || nwr !== 0) begin bad++;
            $display("FAIL lw4 lat=%0d rd=%h err=%b wr=%0d want 2/00000065/0/0", lat, rd, er, nwr); end
    endtask

    task automatic test_sb();
        int lat, nwr; logic [31:0] rd; logic er;
        do_req(1'b1, 3'b000, 32'h5, 32'hAB, lat, rd, er, nwr);
        ref_mem[1] = model_store(ref_mem[1], 0, 5, 32'hAB);
        total++; if (lat !== 3 || er !== 1'b0 || rd !== 32'h0 || nwr !== 1) begin bad++;
            $display("FAIL sb5 lat=%0d err=%b rd=%h wr=%0d want 3/0/0/1", lat, er, rd, nwr); end
        total++; if (last_wr_addr !== 32'h4 || last_wr_data !== 32'h0000AB65) begin bad++;
            $display("FAIL sb5_write addr=%h data=%h want 00000004/0000ab65", last_wr_addr, last_wr_data); end
        do_req(1'b0, 3'b000, 32'h5, 32'h0, lat, rd, er, nwr);
        total++; if (rd !== 32'hFFFFFFAB || lat !== 2) begin bad++;
            $display("FAIL lb5 rd=%h lat=%0d want ffffffab/2", rd, lat); end
        do_req(1'b0, 3'b100, 32'h5, 32'h0, lat, rd, er, nwr);
        total++; if (rd !== 32'h000000AB || er !== 1'b0) begin bad++;
            $display("FAIL lbu5 rd=%h err=%b want 000000ab/0", rd, er); end
    endtask

    task automatic test_sh();
        int lat, nwr; logic [31:0] rd; logic er;
        do_req(1'b1, 3'b001, 32'hA, 32'h1234, lat, rd, er, nwr);
        ref_mem[2] = model_store(ref_mem[2], 1, 10, 32'h1234);
        total++; if (ram[2] !== 32'h12340066 || lat !== 3 || nwr !== 1) begin bad++;
            $display("FAIL sh10 word2=%h lat=%0d wr=%0d want 12340066/3/1", ram[2], lat, nwr); end
        do_req(1'b0, 3'b001, 32'hA, 32'h0, lat, rd, er, nwr);
        total++; if (rd !== 32'h00001234) begin bad++;
            $display("FAIL lh10 rd=%h want 00001234", rd); end
    endtask

    task automatic test_errors();
        int lat, nwr; logic [31:0] rd; logic er;
        logic [2:0]  f3s [4] = '{3'b010, 3'b010, 3'b011, 3'b100};
        bit          wes [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] ads [4] = '{32'h6, 32'h3, 32'h0, 32'h0};
        for (int i = 0; i < 4; i++) begin
            do_req(wes[i], f3s[i], ads[i], 32'hFFFF_FFFF, lat, rd, er, nwr);
            total++; if (lat !== 1 || er !== 1'b1 || rd !== 32'h0 || nwr !== 0) begin bad++;
                $display("FAIL err_case%0d lat=%0d err=%b rd=%h wr=%0d want 1/1/0/0", i, lat, er, rd, nwr); end
        end
        total++; if (ram[0] !== 32'h64) begin bad++;
            $display("FAIL err_word0 got %h want 00000064", ram[0]); end
    endtask

    task automatic test_reset_mid_write();
        int w0 = wr_count;
        bit saw_rsp = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h8; req_wdata = 32'hDEADBEEF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        total++; if (mem_wr_en !== 1'b1 || mem_addr !== 32'h8) begin bad++;
            $display("FAIL sw8_write_cycle wr_en=%b addr=%h want 1/00000008", mem_wr_en, mem_addr); end
        reset = 1'b1;
        #1;
        total++; if (mem_wr_en !== 1'b0) begin bad++;
            $display("FAIL wr_gated_by_reset got %b want 0", mem_wr_en); end
        @(negedge clk);
        saw_rsp |= rsp_valid;
        reset = 1'b0;
        @(negedge clk);
        saw_rsp |= rsp_valid;
        total++; if (req_ready !== 1'b1) begin bad++;
            $display("FAIL ready_after_reset got %b want 1", req_ready); end
        total++; if (saw_rsp || wr_count !== w0 || ram[2] !== ref_mem[2]) begin bad++;
            $display("FAIL abort_effects rsp=%b writes=%0d word2=%h want 0/0/%h", saw_rsp, wr_count - w0, ram[2], ref_mem[2]); end
    endtask

    task automatic test_back_to_back();
        bit          rdy [7];
        bit          vld [7];
        logic [31:0] rdv [7];
        bit          exp_rdy [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        bit          exp_vld [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h4; req_wdata = '0;
        rdy[0] = req_ready; vld[0] = rsp_valid; rdv[0] = rsp_rdata;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            rdy[k] = req_ready; vld[k] = rsp_valid; rdv[k] = rsp_rdata;
            if (k == 1) req_addr = 32'hC;
            if (k == 5) req_valid = 1'b0;
        end
        for (int k = 0; k <= 6; k++) begin
            total++; if (rdy[k] !== exp_rdy[k] || vld[k] !== exp_vld[k]) begin bad++;
                $display("FAIL b2b_cycle%0d ready=%b valid=%b want %b/%b", k, rdy[k], vld[k], exp_rdy[k], exp_vld[k]); end
        end
        total++; if (rdv[2] !== model_load(ref_mem[1], 2, 4) || rdv[5] !== model_load(ref_mem[3], 2, 12)) begin bad++;
            $display("FAIL b2b_data got %h/%h want %h/%h", rdv[2], rdv[5], ref_mem[1], ref_mem[3]); end
    endtask

    task automatic test_random();
        int lat, nwr, addr, f3, diffs;
        bit we;
        logic [31:0] wd, rd, exp_rd;
        logic er;
        bit e;
        for (int n = 0; n < 60; n++) begin
            we   = 1'($urandom_range(0, 1));
            f3   = $urandom_range(0, 7);
            addr = $urandom_range(0, 255);
            wd   = $urandom;
            e    = model_err(we, f3, addr);
            exp_rd = (e || we) ? 32'h0 : model_load(ref_mem[addr / 4], f3, addr);
            do_req(we, 3'(f3), 32'(addr), wd, lat, rd, er, nwr);
            if (we && !e) ref_mem[addr / 4] = model_store(ref_mem[addr / 4], f3, addr, wd);
            total++;
            if (lat !== model_latency(we, f3, addr) || rd !== exp_rd || er !== e || nwr !== ((we && !e) ? 1 : 0)) begin
                bad++;
                $display("FAIL rand%0d we=%0d f3=%0d addr=%0h lat=%0d rd=%h err=%b wr=%0d want %0d/%h/%b/%0d",
                         n, we, f3, addr, lat, rd, er, nwr, model_latency(we, f3, addr), exp_rd, e, (we && !e) ? 1 : 0);
            end
        end
        diffs = 0;
        for (int i = 0; i < 64; i++) if (ram[i] !== ref_mem[i]) diffs++;
        total++; if (diffs != 0) begin bad++;
            $display("FAIL ram_contents differing_words=%0d want 0", diffs); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sb();
        test_sh();
        test_errors();
        test_reset_mid_write();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
